// File: rtl/ecc_memory_scrubber_if.sv
// Host-side and memory-side buses of the ECC memory scrubber.
// The scrubber is the slave of the host bus and the master of the memory bus.
interface scrub_host_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  host_wr_en;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_busy;

  modport master (
    output host_wr_en,
    output host_addr,
    output host_data,
    input  host_busy
  );

  modport slave (
    input  host_wr_en,
    input  host_addr,
    input  host_data,
    output host_busy
  );
endinterface

interface scrub_mem_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_err;

  modport master (
    output mem_wr_en,
    output mem_addr,
    output mem_data,
    input  mem_rd_data,
    input  mem_err
  );

  modport slave (
    input  mem_wr_en,
    input  mem_addr,
    input  mem_data,
    output mem_rd_data,
    output mem_err
  );
endinterface

// File: rtl/ecc_memory_scrubber.sv
// Background scrubber: walks every address of the SEC-protected memory and
// writes back words the decoder had to correct; host writes pass through in idle.
module ecc_memory_scrubber #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SCRUB_PERIOD = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         auto_en,
  scrub_host_if.slave  host,
  scrub_mem_if.master  mem,
  output logic         busy,
  output logic         done,
  output logic         pass_err,
  output logic [7:0]   err_count
);

  localparam int unsigned PER_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCRUB_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PER_W-1:0]      per_cnt_q, per_cnt_d;
  logic                  pass_err_q, pass_err_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  last_addr;

  assign last_addr = (addr_q == '1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    per_cnt_d   = per_cnt_q;
    pass_err_d  = pass_err_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        per_cnt_d = auto_en ? per_cnt_q + PER_W'(1) : '0;
        if (start || (auto_en && per_cnt_q == PER_LAST)) begin
          per_cnt_d  = '0;
          addr_d     = '0;
          pass_err_d = 1'b0;
          state_d    = READ;
        end
      end
      READ:  state_d = (READ_LATENCY == 2) ? WAIT : CHECK;
      WAIT:  state_d = CHECK;
      CHECK: begin
        if (mem.mem_err) begin
          data_d  = mem.mem_rd_data;
          state_d = WRITE;
        end else if (last_addr) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = READ;
        end
      end
      WRITE: begin
        pass_err_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + 8'd1;
        end
        if (last_addr) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      per_cnt_q   <= '0;
      pass_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      per_cnt_q   <= per_cnt_d;
      pass_err_q  <= pass_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Idle passthrough is combinational; gating with rst keeps the memory
  // write strobe low for the whole time reset is asserted.
  always_comb begin
    if (state_q == IDLE) begin
      mem.mem_wr_en = rst & host.host_wr_en;
      mem.mem_addr  = host.host_addr;
      mem.mem_data  = host.host_data;
    end else begin
      mem.mem_wr_en = (state_q == WRITE);
      mem.mem_addr  = addr_q;
      mem.mem_data  = data_q;
    end
  end

  assign busy           = (state_q != IDLE);
  assign host.host_busy = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign pass_err       = pass_err_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_ecc_memory_scrubber.sv
// Directed bench for ecc_memory_scrubber with a registered-read memory model
// and per-address fault injection on the decoder error flag.
module tb_ecc_memory_scrubber;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       auto_en;
  logic       busy;
  logic       done;
  logic       pass_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scrub_host_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();
  scrub_mem_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  ecc_memory_scrubber #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(1),
    .SCRUB_PERIOD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .auto_en  (auto_en),
    .host     (hif),
    .mem      (mif),
    .busy     (busy),
    .done     (done),
    .pass_err (pass_err),
    .err_count(err_count)
  );

  // Memory model: one-cycle registered read, decoder flag injected per address
  logic [DW-1:0] mem_arr [16];
  logic          fault_on;
  logic [AW-1:0] fault_addr;
  logic          force_err;

  always_ff @(posedge clk) begin
    if (mif.mem_wr_en) mem_arr[mif.mem_addr] <= mif.mem_data;
    mif.mem_rd_data <= mem_arr[mif.mem_addr];
    mif.mem_err     <= force_err | (fault_on && (mif.mem_addr == fault_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge inside the first busy cycle; returns at the first idle negedge.
  task automatic monitor_pass(output int busy_cyc, output int wr_cyc, output int done_cyc,
                              output int wa, output int wd, output int first_addr);
    busy_cyc = 0; wr_cyc = 0; done_cyc = 0; wa = -1; wd = -1; first_addr = -1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      if (busy_cyc == 0) first_addr = int'(mif.mem_addr);
      busy_cyc++;
      if (mif.mem_wr_en) begin
        wr_cyc++;
        wa = int'(mif.mem_addr);
        wd = int'(mif.mem_data);
      end
      if (done) done_cyc++;
      @(negedge clk);
    end
    check("pass_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_pass(output int busy_cyc, output int wr_cyc, output int done_cyc,
                          output int wa, output int wd, output int first_addr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    monitor_pass(busy_cyc, wr_cyc, done_cyc, wa, wd, first_addr);
  endtask

  typedef struct {
    logic          rst_v;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int bc, wc, dc, wa, wd, fa, n;

    vecs[0] = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 8'hFF, 1'b0, 4'hF, 8'hFF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'hA, 8'h5A, 1'b1, 4'hA, 8'h5A, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'h7, 8'h81, 1'b0, 4'h7, 8'h81, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'h3, 8'h3C, 1'b0, 4'h3, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'h6, 8'hC3, 1'b1, 4'h6, 8'hC3, 1'b0};

    rst = 1'b0; start = 1'b0; auto_en = 1'b0;
    hif.host_wr_en = 1'b0; hif.host_addr = '0; hif.host_data = '0;
    fault_on = 1'b0; fault_addr = '0; force_err = 1'b0;

    // Reset values, with a host write strobe that must not reach memory
    repeat (2) @(negedge clk);
    hif.host_wr_en = 1'b1;
    #1;
    check("rst_mem_wr_en", 32'(mif.mem_wr_en), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_host_busy", 32'(hif.host_busy), 32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_pass_err",  32'(pass_err),      32'd0);
    check("rst_err_count", 32'(err_count),     32'd0);
    hif.host_wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Idle passthrough table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = vecs[i].rst_v;
      hif.host_wr_en = vecs[i].wr;
      hif.host_addr  = vecs[i].addr;
      hif.host_data  = vecs[i].data;
      #1;
      check($sformatf("vec%0d_wr_en", i), 32'(mif.mem_wr_en), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_addr", i),  32'(mif.mem_addr),  32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i),  32'(mif.mem_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_hbusy", i), 32'(hif.host_busy), 32'(vecs[i].exp_busy));
    end
    @(negedge clk);
    rst = 1'b1;
    hif.host_wr_en = 1'b0;

    // Fill memory with 0xA5
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      hif.host_wr_en = 1'b1; hif.host_addr = AW'(a); hif.host_data = 8'hA5;
    end
    @(negedge clk);
    hif.host_wr_en = 1'b0;

    // Clean pass
    run_pass(bc, wc, dc, wa, wd, fa);
    check("clean_busy_cycles", bc, 33);
    check("clean_writes", wc, 0);
    check("clean_done_pulses", dc, 1);
    check("clean_first_addr", fa, 0);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_pass_err", 32'(pass_err), 32'd0);

    // Single corrected error at address 5
    fault_on = 1'b1; fault_addr = 4'd5;
    run_pass(bc, wc, dc, wa, wd, fa);
    fault_on = 1'b0;
    check("sec_busy_cycles", bc, 34);
    check("sec_writes", wc, 1);
    check("sec_wr_addr", wa, 5);
    check("sec_wr_data", wd, 32'hA5);
    check("sec_err_count", 32'(err_count), 32'd1);
    check("sec_pass_err", 32'(pass_err), 32'd1);

    // start together with a host write, then host writes during the pass
    start = 1'b1;
    hif.host_wr_en = 1'b1; hif.host_addr = 4'd3; hif.host_data = 8'h3C;
    #1;
    check("arb_wr_en", 32'(mif.mem_wr_en), 32'd1);
    check("arb_addr", 32'(mif.mem_addr), 32'd3);
    check("arb_data", 32'(mif.mem_data), 32'h3C);
    @(negedge clk);
    start = 1'b0;
    hif.host_data = 8'hFF;
    check("arb_busy_next", 32'(busy), 32'd1);
    check("arb_host_busy", 32'(hif.host_busy), 32'd1);
    monitor_pass(bc, wc, dc, wa, wd, fa);
    hif.host_wr_en = 1'b0;
    check("arb_busy_cycles", bc, 33);
    check("arb_writes_in_pass", wc, 0);
    check("arb_mem3", 32'(mem_arr[3]), 32'h3C);
    check("arb_pass_err_cleared", 32'(pass_err), 32'd0);
    check("arb_err_count", 32'(err_count), 32'd1);

    // Saturation: 1 + 16*16 corrections clamps at 255
    force_err = 1'b1;
    for (int p = 0; p < 16; p++) run_pass(bc, wc, dc, wa, wd, fa);
    check("sat_busy_cycles", bc, 49);
    check("sat_writes", wc, 16);
    check("sat_err_count", 32'(err_count), 32'd255);
    run_pass(bc, wc, dc, wa, wd, fa);
    check("sat_hold", 32'(err_count), 32'd255);
    force_err = 1'b0;
    run_pass(bc, wc, dc, wa, wd, fa);
    check("sat_clean_pass_err", 32'(pass_err), 32'd0);
    check("sat_clean_err_count", 32'(err_count), 32'd255);

    // Auto mode, period 8
    auto_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int c = 1; c <= 50; c++) begin
        @(negedge clk);
        n = c;
        if (busy) break;
      end
      check($sformatf("auto_gap%0d", k), n, 8);
      monitor_pass(bc, wc, dc, wa, wd, fa);
      check($sformatf("auto_busy%0d", k), bc, 33);
    end
    repeat (4) @(negedge clk);
    auto_en = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("auto_off_no_pass", n, 0);

    // Reset during the write-back at address 9
    fault_on = 1'b1; fault_addr = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (mif.mem_wr_en && mif.mem_addr == 4'd9) begin
        n = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_write9_seen", n, 1);
    hif.host_wr_en = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_mem_wr_en", 32'(mif.mem_wr_en), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_host_busy", 32'(hif.host_busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_pass_err", 32'(pass_err), 32'd0);
    check("mid_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    hif.host_wr_en = 1'b0;
    fault_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run_pass(bc, wc, dc, wa, wd, fa);
    check("restart_first_addr", fa, 0);
    check("restart_busy_cycles", bc, 33);
    check("restart_writes", wc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ecc_memory_scrubber.md
# ecc_memory_scrubber

Background scrubber for the 16-entry Hamming-SEC protected memory. Sits between the host write port and the ECC memory's write/read ports. It walks every address, reads the decoded word and correction flag, and writes corrected data back wherever a single-bit error was corrected. In idle it passes host writes straight through; during a pass it blocks them and keeps correction statistics.

## Interface
- ADDR_WIDTH, 4, memory address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, 8, data word width (pre-encoding).
- READ_LATENCY, 1, cycles from address presented to decoded data/flag valid; legal values 1 or 2.
- SCRUB_PERIOD, 1024, idle cycles between automatic passes when auto_en=1; minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request for one pass.
- auto_en  in  1  enables periodic passes.
- host_wr_en  in  1  host write strobe.
- host_addr  in  ADDR_WIDTH  host write address.
- host_data  in  DATA_WIDTH  host write data.
- host_busy  out  1  host writes are ignored while high.
- mem_wr_en  out  1  to ECC memory write enable.
- mem_addr  out  ADDR_WIDTH  to ECC memory address.
- mem_data  out  DATA_WIDTH  to ECC memory write data (pre-encoder).
- mem_rd_data  in  DATA_WIDTH  decoded read data from ECC memory.
- mem_err  in  1  single-bit-error-corrected flag from decoder.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- pass_err  out  1  last or current pass corrected at least one word.
- err_count  out  8  cumulative corrections, saturating.

## Operation
- FSM states: IDLE, READ, WAIT, CHECK, WRITE, DONE.
- IDLE:
  - mem_addr/mem_data/mem_wr_en combinationally equal host_addr/host_data/host_wr_en.
  - host_busy=0, busy=0.
- Pass trigger, in IDLE only: start=1, or period counter reaching SCRUB_PERIOD-1.
  - Trigger: clears pass_err and the address counter, then moves to READ.
  - start while not IDLE is ignored (not queued).
- Period counter:
  - Increments each IDLE cycle while auto_en=1.
  - Cleared when auto_en=0 or on any pass trigger.
- READ:
  - Drives mem_addr=scrub address, mem_wr_en=0.
  - Next state is WAIT if READ_LATENCY=2, else CHECK.
  - WAIT lasts exactly one cycle, then CHECK.
- CHECK:
  - Samples mem_rd_data and mem_err.
  - mem_err=1: capture data, go to WRITE.
  - mem_err=0: advance address.
- WRITE:
  - One cycle with mem_wr_en=1, mem_addr=scrub address, mem_data=captured data.
  - Sets pass_err.
  - Increments err_count (saturates at 255, no wrap).
  - Then advances address.
- Address advance:
  - If address is 2^ADDR_WIDTH-1, go to DONE (no wrap to 0).
  - Otherwise increment the address and return to READ.
- Address and mem_wr_en=0 are held constant through READ/WAIT/CHECK, so both registered and combinational memory reads work.
- DONE: done=1 for one cycle, then IDLE.
- busy=host_busy=1 in every non-IDLE state.
- Host writes arriving during a pass are dropped; the host must hold until host_busy=0.
- start and host_wr_en together in IDLE: the host write goes to memory that cycle, and the pass starts next cycle.

## Timing
- Reset (rst=0) asynchronously forces:
  - state IDLE
  - mem_wr_en=0 (forced low while rst=0, regardless of host_wr_en)
  - busy=0, host_busy=0, done=0, pass_err=0, err_count=0
  - period counter 0
- Reset mid-pass aborts immediately; no partial write completes after rst falls.
- With start sampled at edge E0, busy is high from E0.
  - Per address: READ_LATENCY+1 cycles, plus 1 cycle if a write-back occurs.
  - Total busy cycles: 16*(READ_LATENCY+1) + corrections + 1 (the DONE cycle).
  - READ_LATENCY=1 with no errors: done is high in the cycle E32–E33, and IDLE resumes at E33.
- err_count and pass_err update on the edge ending WRITE.

## Test plan
- Clean pass:
  - Host writes 0xA5 to all 16 addresses, start=1, mem_err stuck 0.
  - Required: busy high exactly 33 cycles, done pulses once, no mem_wr_en during the pass, err_count=0, pass_err=0.
- Single-error write-back:
  - fault_enable injection active on address 5 only, start.
  - Required: exactly one mem_wr_en cycle, with mem_addr=5 and mem_data=original 0xA5.
  - Required: err_count=1, pass_err=1, busy for 34 cycles.
- Saturation:
  - mem_err forced 1, 16 passes (256 corrections).
  - Required: err_count=255 and holds.
  - Required: next pass with clean data clears pass_err but err_count stays 255.
- Arbitration:
  - start and host_wr_en (addr 3, 0x3C) in the same IDLE cycle: the write reaches memory and the pass follows.
  - host_wr_en during the pass: ignored, host_busy=1, memory addr 3 unchanged by the host.
- Auto mode:
  - SCRUB_PERIOD=8, auto_en=1.
  - Required: a pass starts after 8 idle cycles, and repeats 8 cycles after each done.
  - auto_en=0 mid-count: no pass starts.
- Reset mid-pass:
  - Drop rst during a WRITE at address 9.
  - Required: mem_wr_en=0 immediately, all outputs at reset values, and the next start restarts at address 0.
